// File: rtl/zeroriscy_multdiv_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : zeroriscy_multdiv_ctrl_if
//  Description : Bundles the three handshakes around the multiply/divide
//                controller:
//                  req_* : issue request from decode (valid/ready, operands)
//                  md_*  : enables, operands and ready/result of the core
//                  res_* : result handoff to writeback (valid/ready, data)
//                  flush_i, busy_o, err_o : pipeline control and status
//                The slave modport is the controller's view. The master
//                modport is the view of whatever surrounds it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface zeroriscy_multdiv_ctrl_if;
    // Issue request
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_operator_i;
    logic [1:0]  req_signed_mode_i;
    logic [31:0] req_op_a_i;
    logic [31:0] req_op_b_i;
    logic        flush_i;

    // Multdiv core side
    logic        md_mult_en_o;
    logic        md_div_en_o;
    logic [1:0]  md_operator_o;
    logic [1:0]  md_signed_mode_o;
    logic [31:0] md_op_a_o;
    logic [31:0] md_op_b_o;
    logic        md_equal_to_zero_o;
    logic        md_ready_i;
    logic [31:0] md_result_i;

    // Writeback side and status
    logic        res_valid_o;
    logic        res_ready_i;
    logic [31:0] res_data_o;
    logic        busy_o;
    logic        err_o;

    modport slave (
        input  req_valid_i, req_operator_i, req_signed_mode_i,
        input  req_op_a_i, req_op_b_i, flush_i,
        input  md_ready_i, md_result_i, res_ready_i,
        output req_ready_o,
        output md_mult_en_o, md_div_en_o, md_operator_o, md_signed_mode_o,
        output md_op_a_o, md_op_b_o, md_equal_to_zero_o,
        output res_valid_o, res_data_o, busy_o, err_o
    );

    modport master (
        output req_valid_i, req_operator_i, req_signed_mode_i,
        output req_op_a_i, req_op_b_i, flush_i,
        output md_ready_i, md_result_i, res_ready_i,
        input  req_ready_o,
        input  md_mult_en_o, md_div_en_o, md_operator_o, md_signed_mode_o,
        input  md_op_a_o, md_op_b_o, md_equal_to_zero_o,
        input  res_valid_o, res_data_o, busy_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/zeroriscy_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : zeroriscy_multdiv_ctrl
//  Description : Issue/retire controller wrapped around an iterative
//                multiply/divide core. It accepts one request at a time,
//                holds the operands steady for the core, captures the
//                result and hands it to writeback. A watchdog moves the
//                block into a sticky ERROR state if the core never answers.
//  Parameters  : TIMEOUT_CYCLES - BUSY cycles without md_ready_i before
//                                 ERROR (6-bit counter, so at most 63)
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - zeroriscy_multdiv_ctrl_if.slave (request, core and
//                       writeback handshakes, flush, busy and error status)
//  Revision    : 1.0 - initial release
// ============================================================================
module zeroriscy_multdiv_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 48
) (
    input  wire logic               clk,
    input  wire logic               rst,
    zeroriscy_multdiv_ctrl_if.slave bus
);

    localparam logic [5:0] C_TIMEOUT = 6'(TIMEOUT_CYCLES);
    localparam logic [5:0] C_CNT_MAX = 6'h3F;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BUSY   = 3'd1,
        S_RETIRE = 3'd2,
        S_DONE   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [1:0]  r_operator;
    logic [1:0]  r_signed_mode;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [31:0] r_res_data;
    logic [5:0]  r_cnt;
    logic        r_drop;
    logic        r_err;

    logic        w_accept;
    logic        w_capture;
    logic        w_core_active;
    logic [5:0]  w_cnt_inc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Saturating increment; with the 6-bit counter the compare below can
    // never wrap around and miss the timeout value.
    assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : (r_cnt + 6'd1);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid_i && !bus.flush_i) begin
                    w_accept     = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                // The core cannot be aborted, so a flush only marks the
                // operation for dropping; completion is still awaited.
                if (bus.md_ready_i) begin
                    w_capture    = 1'b1;
                    w_state_next = S_RETIRE;
                end else if (w_cnt_inc == C_TIMEOUT) begin
                    w_state_next = S_ERROR;
                end
            end
            S_RETIRE: begin
                // Enables stay asserted for this one cycle so the core sees
                // its handshake complete and drops back to idle.
                if (r_drop || bus.flush_i) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.flush_i || bus.res_ready_i) begin
                    w_state_next = S_IDLE;
                end
            end
            S_ERROR: begin
                w_state_next = S_ERROR;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture: operands are frozen until the next acceptance
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_operator    <= 2'b00;
            r_signed_mode <= 2'b00;
            r_op_a        <= 32'h0;
            r_op_b        <= 32'h0;
        end else if (w_accept) begin
            r_operator    <= bus.req_operator_i;
            r_signed_mode <= bus.req_signed_mode_i;
            r_op_a        <= bus.req_op_a_i;
            r_op_b        <= bus.req_op_b_i;
        end
    end

    // ------------------------------------------------------------------
    // Result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_data <= 32'h0;
        end else if (w_capture) begin
            r_res_data <= bus.md_result_i;
        end
    end

    // ------------------------------------------------------------------
    // Drop flag: set by a flush while the core is still working on the
    // operation, cleared only when a new operation is accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= 1'b0;
        end else if (w_accept) begin
            r_drop <= 1'b0;
        end else if (bus.flush_i && ((r_state == S_BUSY) || (r_state == S_RETIRE))) begin
            r_drop <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Watchdog counter: counts only consecutive BUSY cycles without a
    // ready strobe and is zero in every other state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 6'd0;
        end else if ((r_state == S_BUSY) && (w_state_next == S_BUSY)) begin
            r_cnt <= w_cnt_inc;
        end else begin
            r_cnt <= 6'd0;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error, cleared only by reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_state_next == S_ERROR) begin
            r_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_core_active = (r_state == S_BUSY) || (r_state == S_RETIRE);

    // rst is folded in so that req_ready_o stays low while reset is held,
    // even though the state register already reads IDLE.
    assign bus.req_ready_o        = (r_state == S_IDLE) && !bus.flush_i && !rst;

    assign bus.md_mult_en_o       = w_core_active && !r_operator[1];
    assign bus.md_div_en_o        = w_core_active &&  r_operator[1];
    assign bus.md_operator_o      = r_operator;
    assign bus.md_signed_mode_o   = r_signed_mode;
    assign bus.md_op_a_o          = r_op_a;
    assign bus.md_op_b_o          = r_op_b;
    assign bus.md_equal_to_zero_o = (r_op_b == 32'h0);

    assign bus.res_valid_o        = (r_state == S_DONE);
    assign bus.res_data_o         = r_res_data;
    assign bus.busy_o             = (r_state != S_IDLE);
    assign bus.err_o              = r_err;

endmodule
`default_nettype wire

// File: tb/tb_zeroriscy_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zeroriscy_multdiv_ctrl
//  Description : Directed bench for zeroriscy_multdiv_ctrl. A behavioural
//                multdiv core answers after a programmable number of enabled
//                cycles; expected results are queued at issue time and
//                compared when writeback takes them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_zeroriscy_multdiv_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    zeroriscy_multdiv_ctrl_if bus();

    zeroriscy_multdiv_ctrl #(.TIMEOUT_CYCLES(48)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] sb_q[$];

    // ------------------------------------------------------------------
    // Behavioural multdiv core
    // ------------------------------------------------------------------
    function automatic logic [31:0] core_fn(input logic [1:0] op, input logic [1:0] mode,
                                            input logic [31:0] a, input logic [31:0] b);
        logic signed [32:0] ea;
        logic signed [32:0] eb;
        logic signed [65:0] p;
        logic               sgn;
        ea  = {mode[0] & a[31], a};
        eb  = {mode[1] & b[31], b};
        p   = ea * eb;
        sgn = &mode;
        case (op)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
            2'd2: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                if (sgn) return $signed(a) / $signed(b);
                return a / b;
            end
            default: begin
                if (b == 32'h0) return a;
                if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                if (sgn) return $signed(a) % $signed(b);
                return a % b;
            end
        endcase
    endfunction

    int core_lat  = 1;
    bit core_hang = 1'b0;
    int core_cnt  = 0;

    always @(posedge clk) begin
        if (rst || !(bus.md_mult_en_o || bus.md_div_en_o)) core_cnt <= 0;
        else                                               core_cnt <= core_cnt + 1;
    end

    assign bus.md_ready_i  = (bus.md_mult_en_o || bus.md_div_en_o) && !core_hang &&
                             (core_cnt == core_lat - 1);
    assign bus.md_result_i = core_fn(bus.md_operator_o, bus.md_signed_mode_o,
                                     bus.md_op_a_o, bus.md_op_b_o);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] out_vec();
        return {bus.md_mult_en_o, bus.md_div_en_o, bus.res_valid_o, bus.busy_o,
                bus.err_o, bus.req_ready_o, bus.md_equal_to_zero_o};
    endfunction

    // Issues one operation and follows it until writeback takes it (or, for a
    // flushed operation, until the block is idle again). Cycle 0 is the
    // accept cycle; valid_cyc is the first cycle with res_valid_o high.
    task automatic run_op(input logic [1:0] op, input logic [1:0] mode,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int flush_at, input int hold,
                          output int valid_cyc, output int en_cnt,
                          output logic [31:0] data, output logic eqz1);
        int          c;
        int          done_cnt;
        bit          fin;
        bit          held_ok;
        bit          md_ok;
        logic [31:0] first;
        core_lat  = lat;
        valid_cyc = 0;
        en_cnt    = 0;
        data      = 32'h0;
        eqz1      = 1'b0;
        done_cnt  = 0;
        fin       = 1'b0;
        held_ok   = 1'b1;
        md_ok     = 1'b1;
        first     = 32'h0;
        cyc();
        bus.req_valid_i       = 1'b1;
        bus.req_operator_i    = op;
        bus.req_signed_mode_i = mode;
        bus.req_op_a_i        = a;
        bus.req_op_b_i        = b;
        bus.res_ready_i       = (hold == 0);
        @(negedge clk);
        check("accept_ready", 32'(bus.req_ready_o), 32'd1);
        if (flush_at == 0) sb_q.push_back(core_fn(op, mode, a, b));
        c = 0;
        while (!fin && c < 120) begin
            cyc();
            c++;
            bus.req_valid_i = 1'b0;
            bus.req_op_a_i  = ~a;
            bus.req_op_b_i  = ~b;
            bus.flush_i     = (c == flush_at);
            bus.res_ready_i = (done_cnt >= hold);
            @(negedge clk);
            if (c == 1) eqz1 = bus.md_equal_to_zero_o;
            if (bus.md_mult_en_o || bus.md_div_en_o) en_cnt++;
            if (bus.busy_o && (bus.md_op_a_o !== a || bus.md_op_b_o !== b ||
                               bus.md_operator_o !== op || bus.md_signed_mode_o !== mode))
                md_ok = 1'b0;
            if (bus.res_valid_o) begin
                if (valid_cyc == 0) begin
                    valid_cyc = c;
                    first     = bus.res_data_o;
                end
                if (bus.res_data_o !== first || bus.req_ready_o) held_ok = 1'b0;
                if (bus.res_ready_i) begin
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_result", 32'(bus.res_valid_o), 32'd0);
                    end else begin
                        check("sb_result", bus.res_data_o, sb_q.pop_front());
                    end
                    data = bus.res_data_o;
                    fin  = 1'b1;
                end
                done_cnt++;
            end
            if (flush_at != 0 && c > flush_at && !bus.busy_o) fin = 1'b1;
        end
        bus.flush_i = 1'b0;
        check("op_finished", 32'(fin), 32'd1);
        check("md_operands_held", 32'(md_ok), 32'd1);
        if (hold > 0) check("done_hold_stable", 32'(held_ok), 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int          vc;
        int          en;
        int          busy_cnt;
        int          err_cyc;
        logic [31:0] d;
        logic        eqz;
        bit          ok;

        rst                   = 1'b1;
        bus.req_valid_i       = 1'b0;
        bus.req_operator_i    = 2'd0;
        bus.req_signed_mode_i = 2'd0;
        bus.req_op_a_i        = 32'h0;
        bus.req_op_b_i        = 32'h0;
        bus.flush_i           = 1'b0;
        bus.res_ready_i       = 1'b1;

        // Reset state
        cyc(); cyc();
        @(negedge clk);
        check("reset_outputs", 32'(out_vec()), 32'b000_0001);
        check("reset_res_data", bus.res_data_o, 32'h0);
        check("reset_md_op_a", bus.md_op_a_o, 32'h0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(bus.req_ready_o), 32'd1);

        // MULL 7 x 6, core answers on its 33rd enabled cycle
        run_op(2'd0, 2'd0, 32'd7, 32'd6, 33, 0, 0, vc, en, d, eqz);
        check("mull_latency", 32'(vc), 32'd35);
        check("mull_en_cycles", 32'(en), 32'd34);
        check("mull_data", d, 32'd42);

        // Flush in IDLE suppresses acceptance
        cyc();
        bus.req_valid_i = 1'b1;
        bus.flush_i     = 1'b1;
        @(negedge clk);
        check("flush_idle_ready", 32'(bus.req_ready_o), 32'd0);
        cyc();
        bus.req_valid_i = 1'b0;
        bus.flush_i     = 1'b0;
        @(negedge clk);
        check("flush_idle_not_busy", 32'(bus.busy_o), 32'd0);

        // Signed DIV by zero
        run_op(2'd2, 2'd3, 32'h8000_0000, 32'h0, 5, 0, 0, vc, en, d, eqz);
        check("div0_eqz", 32'(eqz), 32'd1);
        check("div0_latency", 32'(vc), 32'd7);
        check("div0_data", d, 32'hFFFF_FFFF);

        // REM flushed at BUSY cycle 5: runs to completion, result dropped
        run_op(2'd3, 2'd3, 32'd100, 32'd7, 20, 5, 0, vc, en, d, eqz);
        check("flush_no_valid", 32'(vc), 32'd0);
        check("flush_en_cycles", 32'(en), 32'd21);
        check("flush_eqz", 32'(eqz), 32'd0);

        // Next request after the flush: signed MULH -3 x 5
        run_op(2'd1, 2'd3, 32'hFFFF_FFFD, 32'd5, 3, 0, 0, vc, en, d, eqz);
        check("mulh_s_latency", 32'(vc), 32'd5);
        check("mulh_s_data", d, 32'hFFFF_FFFF);

        // Unsigned MULH of all-ones operands
        run_op(2'd1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, 0, vc, en, d, eqz);
        check("mulh_u_data", d, 32'hFFFF_FFFE);

        // Result held in DONE for 10 cycles with res_ready_i low
        run_op(2'd2, 2'd0, 32'd100, 32'd7, 4, 0, 10, vc, en, d, eqz);
        check("hold_latency", 32'(vc), 32'd6);
        check("hold_data", d, 32'd14);
        cyc();
        @(negedge clk);
        check("hold_back_idle", 32'({bus.busy_o, bus.req_ready_o}), 32'b01);

        // Reset at BUSY cycle 10
        core_lat = 40;
        cyc();
        bus.req_valid_i       = 1'b1;
        bus.req_operator_i    = 2'd0;
        bus.req_signed_mode_i = 2'd0;
        bus.req_op_a_i        = 32'd3;
        bus.req_op_b_i        = 32'd5;
        @(negedge clk);
        check("rst_mid_accept", 32'(bus.req_ready_o), 32'd1);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            bus.req_valid_i = 1'b0;
            if (i == 10) rst = 1'b1;
        end
        cyc();
        @(negedge clk);
        check("rst_mid_outputs", 32'(out_vec()), 32'b000_0001);
        check("rst_mid_res_data", bus.res_data_o, 32'h0);
        check("rst_mid_md_op_b", bus.md_op_b_o, 32'h0);
        cyc();
        rst = 1'b0;
        ok  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.res_valid_o || bus.busy_o) ok = 1'b1;
            cyc();
        end
        check("rst_mid_no_valid", 32'(ok), 32'd0);

        // Core never answers: watchdog error
        core_hang = 1'b1;
        cyc();
        bus.req_valid_i    = 1'b1;
        bus.req_operator_i = 2'd2;
        bus.req_op_a_i     = 32'd9;
        bus.req_op_b_i     = 32'd3;
        @(negedge clk);
        check("err_accept", 32'(bus.req_ready_o), 32'd1);
        busy_cnt = 0;
        err_cyc  = 0;
        for (int c = 1; c <= 80 && err_cyc == 0; c++) begin
            cyc();
            bus.req_valid_i = 1'b0;
            @(negedge clk);
            if (bus.busy_o && !bus.err_o) busy_cnt++;
            if (bus.err_o) err_cyc = c;
        end
        check("err_cycle", 32'(err_cyc), 32'd49);
        check("err_busy_cycles", 32'(busy_cnt), 32'd48);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            bus.req_valid_i = 1'b1;
            @(negedge clk);
            if (bus.md_mult_en_o || bus.md_div_en_o || bus.req_ready_o ||
                !bus.err_o || !bus.busy_o)
                ok = 1'b0;
        end
        check("err_sticky", 32'(ok), 32'd1);
        cyc();
        bus.req_valid_i = 1'b0;
        rst             = 1'b1;
        core_hang       = 1'b0;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("err_cleared", 32'({bus.err_o, bus.busy_o, bus.req_ready_o}), 32'b001);

        // Recovery: MULL after the error is cleared
        run_op(2'd0, 2'd1, 32'h1234_5678, 32'd3, 1, 0, 0, vc, en, d, eqz);
        check("recover_latency", 32'(vc), 32'd3);
        check("recover_data", d, 32'h369D_0368);

        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
